// File: rtl/sccomp_ahb_mux.sv
// AHB-Lite data-phase response mux with a built-in default slave.
// Unmapped active transfers get a two-cycle ERROR response, and the faulting address is latched.
module sccomp_ahb_mux #(
  parameter int unsigned NSLV = 3
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [NSLV-1:0] HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic [31:0]     HRDATA0,
  input  logic [31:0]     HRDATA1,
  input  logic [31:0]     HRDATA2,
  input  logic [NSLV-1:0] HREADYOUT,
  input  logic [NSLV-1:0] HRESP_S,
  output logic [31:0]     HRDATA,
  output logic            HREADY,
  output logic            HRESP,
  output logic            BUS_ERR,
  output logic [31:0]     ERR_ADDR
);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

  state_e          state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d, sel_low;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [31:0]     rdata_vec [NSLV];
  logic            active, unmapped;

  assign active   = HTRANS[1];
  assign unmapped = active && (HSEL == '0);

  for (genvar g = 0; g < NSLV; g++) begin : g_rdata
    if (g == 0) begin : g_s0
      assign rdata_vec[g] = HRDATA0;
    end else if (g == 1) begin : g_s1
      assign rdata_vec[g] = HRDATA1;
    end else if (g == 2) begin : g_s2
      assign rdata_vec[g] = HRDATA2;
    end else begin : g_none
      assign rdata_vec[g] = '0;
    end
  end

  // Reduce an illegal multi-hot select to its lowest set bit.
  always_comb begin
    sel_low = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (HSEL[k]) begin
        sel_low    = '0;
        sel_low[k] = 1'b1;
      end
    end
  end

  // ERR1 is the only state that drives HREADY low on its own, so every other state samples
  // the address phase whenever the bus is ready.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    err_addr_d = err_addr_q;
    case (state_q)
      StErr1: state_d = StErr2;
      default: begin
        if (HREADY) begin
          sel_d = active ? sel_low : '0;
          if (unmapped) begin
            state_d    = StErr1;
            err_addr_d = HADDR;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_comb begin
    HRDATA  = '0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    BUS_ERR = 1'b0;
    case (state_q)
      StErr1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      StErr2: begin
        HRESP   = 1'b1;
        BUS_ERR = 1'b1;
      end
      default: begin
        for (int k = 0; k < NSLV; k++) begin
          if (sel_q[k]) begin
            HRDATA = rdata_vec[k];
            HREADY = HREADYOUT[k];
            HRESP  = HRESP_S[k];
          end
        end
      end
    endcase
  end

  assign ERR_ADDR = err_addr_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_sccomp_ahb_mux.sv
// Bench for sccomp_ahb_mux: directed bus scenarios followed by random traffic,
// checked each cycle against a transaction-level model.
module tb_sccomp_ahb_mux;
  localparam int NSLV = 3;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [NSLV-1:0] HSEL;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [31:0]     HRDATA0, HRDATA1, HRDATA2;
  logic [NSLV-1:0] HREADYOUT;
  logic [NSLV-1:0] HRESP_S;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic            BUS_ERR;
  logic [31:0]     ERR_ADDR;

  sccomp_ahb_mux #(.NSLV(NSLV)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA0(HRDATA0), .HRDATA1(HRDATA1), .HRDATA2(HRDATA2),
    .HREADYOUT(HREADYOUT), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .BUS_ERR(BUS_ERR), .ERR_ADDR(ERR_ADDR)
  );

  always #5 HCLK = ~HCLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_buserr = 0;

  // Model: the transfer currently in its data phase.
  // m_kind = -1 none, 0..NSLV-1 mapped slave, NSLV unmapped (m_phase counts 1..2).
  int          m_kind;
  int          m_phase;
  logic [31:0] m_err_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lowest(input logic [NSLV-1:0] s);
    for (int i = 0; i < NSLV; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] slave_data(input int k);
    case (k)
      0: return HRDATA0;
      1: return HRDATA1;
      default: return HRDATA2;
    endcase
  endfunction

  task automatic model_reset();
    m_kind = -1;
    m_phase = 0;
    m_err_addr = '0;
  endtask

  task automatic expect_now(output logic [31:0] d, output logic r, output logic rs,
                            output logic be);
    d = '0; r = 1'b1; rs = 1'b0; be = 1'b0;
    if (m_kind == NSLV) begin
      rs = 1'b1;
      r  = (m_phase == 2);
      be = (m_phase == 2);
    end else if (m_kind >= 0) begin
      d  = slave_data(m_kind);
      r  = HREADYOUT[m_kind];
      rs = HRESP_S[m_kind];
    end
  endtask

  // Called mid-low-phase: compare outputs, then advance the model across the next rising edge.
  task automatic cycle();
    logic [31:0] ed;
    logic er, ers, ebe;
    #1;
    expect_now(ed, er, ers, ebe);
    chk("hrdata", HRDATA, ed);
    chk("hready", {31'b0, HREADY}, {31'b0, er});
    chk("hresp", {31'b0, HRESP}, {31'b0, ers});
    chk("bus_err", {31'b0, BUS_ERR}, {31'b0, ebe});
    chk("err_addr", ERR_ADDR, m_err_addr);
    if (BUS_ERR) n_buserr++;
    if (er) begin
      if (HTRANS[1]) begin
        if (HSEL == '0) begin
          m_kind = NSLV;
          m_phase = 1;
          m_err_addr = HADDR;
        end else begin
          m_kind = lowest(HSEL);
        end
      end else begin
        m_kind = -1;
      end
    end else if (m_kind == NSLV) begin
      m_phase = 2;
    end
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic drive(input logic [NSLV-1:0] sel, input logic [1:0] trans,
                       input logic [31:0] addr, input logic [NSLV-1:0] rdy);
    HSEL = sel;
    HTRANS = trans;
    HADDR = addr;
    HREADYOUT = rdy;
    cycle();
  endtask

  initial begin
    HRESET = 1'b1;
    HSEL = '0; HADDR = '0; HTRANS = 2'b00; HREADYOUT = '1; HRESP_S = '0;
    HRDATA0 = 32'h0000_1111; HRDATA1 = 32'hDEAD_BEEF; HRDATA2 = 32'h0000_2222;
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    cycle();  // reset values
    HRESET = 1'b0;

    // Zero-wait read from slave 1
    drive(3'b010, 2'b10, 32'h1000_0000, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);

    // GPIO with two wait states; the slave 0 address phase waits on HREADY
    drive(3'b100, 2'b10, 32'h2000_0000, 3'b111);
    drive(3'b001, 2'b10, 32'h0000_0040, 3'b011);
    drive(3'b001, 2'b10, 32'h0000_0040, 3'b011);
    drive(3'b001, 2'b10, 32'h0000_0040, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);

    // Unmapped access
    drive(3'b000, 2'b10, 32'hBF00_0010, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);

    // Back-to-back unmapped: second is captured at the end of ERR2
    drive(3'b000, 2'b10, 32'h0000_0001, 3'b111);
    drive(3'b000, 2'b10, 32'h0000_0002, 3'b111);
    drive(3'b000, 2'b10, 32'h0000_0002, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    chk("err_addr_b2b", ERR_ADDR, 32'h0000_0002);
    chk("buserr_pulses", n_buserr, 3);

    // IDLE transfer to nothing, then multi-hot select
    drive(3'b000, 2'b00, 32'hBF00_0020, 3'b111);
    drive(3'b110, 2'b10, 32'h1000_0004, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);
    drive(3'b000, 2'b00, 32'h0, 3'b111);

    // Reset asserted during ERR1, master cancels at the same time
    drive(3'b000, 2'b10, 32'hCAFE_0000, 3'b111);
    HTRANS = 2'b00;
    #1;
    chk("err1_hready", {31'b0, HREADY}, 32'd0);
    HRESET = 1'b1;
    #1;
    model_reset();
    chk("rst_hready", {31'b0, HREADY}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_bus_err", {31'b0, BUS_ERR}, 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      HSEL = NSLV'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) HSEL = '0;
      HTRANS = 2'($urandom_range(0, 3));
      HADDR = $urandom();
      for (int b = 0; b < NSLV; b++) begin
        HREADYOUT[b] = ($urandom_range(0, 3) != 0);
        HRESP_S[b]   = ($urandom_range(0, 9) == 0);
      end
      HRDATA0 = $urandom();
      HRDATA1 = $urandom();
      HRDATA2 = $urandom();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
